// File: rtl/serial_subtractor_if.sv
// Handshake/operand bundle for serial_subtractor.
// The overflow signal exists only when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             overflow;
`endif

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
    , input overflow
`endif
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
    , output overflow
`endif
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor {borrow, diff} = a - b - bin, LSB first, WIDTH cycles.
// Optional signed-overflow output enabled by SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus,
  output logic [1:0]          state_o
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; in_ready is high only in IDLE, out_valid only in DONE, and DONE holds
  // its outputs until out_ready, so a new operand set is never taken in that cycle.

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_q, diff_q;
  logic             br_q, borrow_q;
  logic             accept, last_bit, d_bit, br_next;
  logic [WIDTH-1:0] res_d;

  assign accept   = (state_q == IDLE) && bus.in_valid;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign d_bit    = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
  assign br_next  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
  assign res_d    = {d_bit, res_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = CALC;
      CALC:    if (last_bit) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.diff      = diff_q;
    bus.borrow    = borrow_q;
    state_o       = state_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (accept) begin
      a_sh_q <= bus.a;
      b_sh_q <= bus.b;
      br_q   <= bus.bin;
      res_q  <= '0;
      cnt_q  <= '0;
    end else if (state_q == CALC) begin
      a_sh_q <= a_sh_q >> 1;
      b_sh_q <= b_sh_q >> 1;
      res_q  <= res_d;
      br_q   <= br_next;
      cnt_q  <= cnt_q + 1'b1;
      if (last_bit) begin
        diff_q   <= res_d;
        borrow_q <= br_next;
      end
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  // Operand sign bits are shifted out during CALC, so keep copies for the overflow term.
  logic sign_a_q, sign_b_q, overflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      sign_a_q <= bus.a[WIDTH-1];
      sign_b_q <= bus.b[WIDTH-1];
    end else if ((state_q == CALC) && last_bit) begin
      overflow_q <= (sign_a_q ^ sign_b_q) & (d_bit ^ sign_a_q);
    end
  end

  assign bus.overflow = overflow_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus randomized traffic
// compared against an arithmetic reference model through an expected-result queue.
module tb_serial_subtractor;
  localparam int WIDTH = 4;
  localparam int EW    = WIDTH + 2;
  localparam int N_RND = 1000;

  logic       clk;
  logic       rst;
  logic [1:0] state_o;
  int         checks;
  int         errors;
  logic [EW-1:0] exp_q[$];

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Returns {overflow, borrow, diff}; overflow uses the signed-overflow rule of the block.
  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic bin);
    int r;
    logic [31:0] rv;
    logic [WIDTH-1:0] d;
    logic br, ov;
    r  = int'(a) - int'(b) - int'(bin);
    rv = r;
    d  = rv[WIDTH-1:0];
    br = (r < 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    ov = (a[WIDTH-1] ^ b[WIDTH-1]) & (d[WIDTH-1] ^ a[WIDTH-1]);
`else
    ov = 1'b0;
`endif
    return {ov, br, d};
  endfunction

  function automatic logic dut_ov();
`ifdef SERIAL_SUB_OVERFLOW_EN
    return bus.overflow;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Presents operands until accepted; returns at acceptance edge + 1.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic bin, output bit ok);
    bit was_ready;
    ok = 1'b0;
    bus.a = a; bus.b = b; bus.bin = bin; bus.in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      was_ready = bus.in_ready;
      @(posedge clk);
      #1;
      if (was_ready) begin
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // Full transaction: accept, measure latency, check result, complete handshake.
  task automatic do_txn(input string name, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic bin);
    bit ok;
    int lat;
    logic [EW-1:0] exp;
    exp = model(a, b, bin);
    send(a, b, bin, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s accept: in_ready never seen", name);
      return;
    end
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat !== WIDTH) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, WIDTH);
    end
    checks++;
    if ({dut_ov(), bus.borrow, bus.diff} !== exp) begin
      errors++;
      $display("FAIL %s result: got ov=%0b br=%0b d=%0d expected ov=%0b br=%0b d=%0d",
               name, dut_ov(), bus.borrow, bus.diff, exp[EW-1], exp[WIDTH], exp[WIDTH-1:0]);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s in_ready_in_done: got %0b expected 0", name, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s post_handshake: got in_ready=%0b out_valid=%0b expected 1/0",
               name, bus.in_ready, bus.out_valid);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.borrow, dut_ov(), bus.diff, state_o} !==
        {1'b1, 1'b0, 1'b0, 1'b0, {WIDTH{1'b0}}, 2'd0}) begin
      errors++;
      $display("FAIL reset: got rdy=%0b vld=%0b br=%0b ov=%0b d=%0d st=%0d expected 1 0 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.borrow, dut_ov(), bus.diff, state_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit ok;
    send(4'd9, 4'd3, 1'b0, ok);
    checks++;
    if (!ok || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic accept: ok=%0b in_ready=%0b expected 1/0", ok, bus.in_ready);
    end
    for (int i = 1; i < WIDTH; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL basic early_valid T+%0d: got vld=%0b rdy=%0b expected 0/0",
                 i, bus.out_valid, bus.in_ready);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.diff !== 4'd6 || bus.borrow !== 1'b0) begin
      errors++;
      $display("FAIL basic T+4: got vld=%0b d=%0d br=%0b expected 1 6 0",
               bus.out_valid, bus.diff, bus.borrow);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic handshake: got rdy=%0b vld=%0b expected 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_boundaries();
    do_txn("a3_b9_bin1",   4'd3,  4'd9,  1'b1);
    do_txn("full_wrap",    4'd0,  4'd15, 1'b1);
    do_txn("equal",        4'd15, 4'd15, 1'b0);
    do_txn("zero_zero_b1", 4'd0,  4'd0,  1'b1);
  endtask

  task automatic test_stall();
    bit ok;
    int lat;
    send(4'd5, 4'd2, 1'b0, ok);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (!ok || lat !== WIDTH) begin
      errors++;
      $display("FAIL stall setup: ok=%0b latency=%0d expected 1/%0d", ok, lat, WIDTH);
    end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i == 2); bus.a = 4'd1; bus.b = 4'd1; bus.bin = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.diff !== 4'd3 || bus.borrow !== 1'b0 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall hold %0d: got vld=%0b d=%0d br=%0b rdy=%0b expected 1 3 0 0",
                 i, bus.out_valid, bus.diff, bus.borrow, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall release: got rdy=%0b vld=%0b expected 1/0", bus.in_ready, bus.out_valid);
    end
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall ignored_pair %0d: got out_valid=%0b expected 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_abort();
    bit ok;
    send(4'd12, 4'd4, 1'b0, ok);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.borrow, dut_ov(), bus.diff, state_o} !==
        {1'b1, 1'b0, 1'b0, 1'b0, {WIDTH{1'b0}}, 2'd0}) begin
      errors++;
      $display("FAIL abort reset_values: got rdy=%0b vld=%0b br=%0b ov=%0b d=%0d st=%0d expected 1 0 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.borrow, dut_ov(), bus.diff, state_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort no_valid %0d: got out_valid=%0b expected 0", i, bus.out_valid);
      end
    end
    do_txn("after_abort", 4'd7, 4'd2, 1'b0);
  endtask

`ifdef SERIAL_SUB_OVERFLOW_EN
  task automatic test_overflow();
    do_txn("ov_8_1",  4'd8, 4'd1,  1'b0);
    do_txn("ov_7_15", 4'd7, 4'd15, 1'b0);
    do_txn("ov_6_2",  4'd6, 4'd2,  1'b0);
  endtask
`endif

  task automatic test_back_to_back();
    int received;
    received = 0;
    fork
      begin : driver
        bit ok;
        logic [WIDTH-1:0] ra, rb;
        logic rbin;
        for (int n = 0; n < N_RND; n++) begin
          ra = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
          rb = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
          rbin = 1'($urandom_range(0, 1));
          send(ra, rb, rbin, ok);
          if (!ok) break;
          exp_q.push_back(model(ra, rb, rbin));
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
        end
      end
      begin : monitor
        bit seen_valid, rdy;
        logic [EW-1:0] got, exp;
        int cyc;
        cyc = 0;
        while (received < N_RND && cyc < 40000) begin
          seen_valid = bus.out_valid;
          got = {dut_ov(), bus.borrow, bus.diff};
          rdy = ($urandom_range(0, 2) != 0);
          bus.out_ready = rdy;
          @(posedge clk);
          if (seen_valid && rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL rnd duplicate: result %0h with empty expected queue", got);
            end else begin
              exp = exp_q.pop_front();
              if (got !== exp) begin
                errors++;
                $display("FAIL rnd result %0d: got %0h expected %0h", received, got, exp);
              end
            end
            received++;
          end
          #1;
          cyc++;
        end
        bus.out_ready = 1'b0;
      end
    join
    checks++;
    if (received !== N_RND || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL rnd count: got %0d results, %0d pending expected %0d and 0",
               received, exp_q.size(), N_RND);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_boundaries();
    test_stall();
    test_abort();
`ifdef SERIAL_SUB_OVERFLOW_EN
    test_overflow();
`endif
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor with valid/ready handshakes on both sides. It computes {borrow, diff} = a − b − bin one bit per clock, LSB first, and is the inverse companion of the combinational 4-bit full adder. It sits behind the adder in the arithmetic playground, where it recovers operands from adder results, and it is verified against the same golden-model flow.

## Interface
- WIDTH, 4, operand/difference width in bits (≥2)
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operands on a/b/bin are valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  diff/borrow hold a valid result
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  difference, (a − b − bin) mod 2^WIDTH
- borrow  output  1  borrow-out; 1 iff a < b + bin (unsigned)
- overflow  output  1  signed overflow; present only with SERIAL_SUB_OVERFLOW_EN

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid && in_ready, latch a, b, bin into shift registers, clear the bit counter, and go to CALC.
- CALC: each cycle, take the LSBs a0/b0 and the running borrow br:
  - d = a0 ^ b0 ^ br
  - br' = (~a0 & b0) | (~(a0 ^ b0) & br)
  - shift d into the result register from the MSB end and shift the operands right.
- After WIDTH CALC cycles, load diff, borrow (and overflow) output registers and go to DONE.
- DONE: out_valid=1. diff/borrow/overflow are held stable. On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. The next operands are not accepted in the same cycle as the output handshake.
- Outputs keep the last result after the handshake. They are meaningful only while out_valid=1.
- Boundary cases:
  - a=b, bin=0: diff=0, borrow=0.
  - a=0, b=2^WIDTH−1, bin=1: diff=0, borrow=1 (full wrap).
- Reset at any time aborts the operation. No out_valid is produced for the aborted operands.

## Timing
- Reset values: in_ready=1, out_valid=0, diff=0, borrow=0, overflow=0. The FSM is in IDLE and the counter and shift registers are 0.
- Acceptance edge = T. CALC occupies the cycles after edges T+1..T+WIDTH. out_valid rises after edge T+WIDTH, i.e. latency is WIDTH cycles.
- in_ready falls after edge T and rises again after the edge that completes the out_valid && out_ready handshake.
- Minimum initiation interval: WIDTH+2 cycles (IDLE, WIDTH×CALC, DONE with out_ready=1).
- out_valid held with out_ready=0: the block stalls in DONE indefinitely with outputs unchanged.
- All outputs are registered. in_ready and out_valid are decoded directly from state flops.

## Configuration
- SERIAL_SUB_OVERFLOW_EN defined:
  - adds the overflow output port;
  - overflow = (a[WIDTH−1] ^ b[WIDTH−1]) & (diff[WIDTH−1] ^ a[WIDTH−1]), using the latched operands;
  - registered with diff and held through DONE.
- Not defined:
  - no overflow port and no associated logic;
  - all other behaviour is identical.

## Test plan
- a=9, b=3, bin=0 accepted at edge T -> out_valid first high after edge T+4; diff=6, borrow=0; in_ready low T+1..handshake.
- a=3, b=9, bin=1 -> diff=9, borrow=1. Then a=0, b=15, bin=1 -> diff=0, borrow=1. Then a=15, b=15, bin=0 -> diff=0, borrow=0.
- Result a=5, b=2 with out_ready held low 5 cycles and in_valid pulsed with a=1, b=1 during the stall -> out_valid, diff=3 and borrow=0 held steady; the second operand pair is ignored; in_ready returns 1 one cycle after out_ready is raised.
- rst asserted 2 cycles into CALC (a=12, b=4) -> outputs at reset values immediately; no out_valid; next operands a=7, b=2 yield diff=5 after 4 cycles.
- With SERIAL_SUB_OVERFLOW_EN:
  - a=8, b=1, bin=0 -> diff=7, overflow=1;
  - a=7, b=15, bin=0 -> diff=8, overflow=1, borrow=1;
  - a=6, b=2 -> overflow=0.
  - Without the macro the port is absent and the other checks still pass.
- 1000 random back-to-back transactions with random out_ready stalls -> every result matches the golden {borrow, diff} = a − b − bin; zero lost or duplicated outputs.
